// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-input round-robin output register.
// Holds the EMPTY/FULL state enum and the source-select encodings that are
// used for the sel output and the round-robin pointer.
package mux2_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic SEL_D0 = 1'b0;
    localparam logic SEL_D1 = 1'b1;

endpackage

// File: rtl/rr_grant2.sv
// Two-requester round-robin grant, purely combinational.
// Ports: req[1:0] request vector, ptr = requester favoured on contention,
//        grant[1:0] one-hot grant (all zero when nobody requests).
module rr_grant2
    import mux2_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr == SEL_D1) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mux2_arb.sv
// Two-input round-robin arbiter feeding a single registered output stage.
// Ports: clk, rst_n (async active-low); d0/d1 valid-ready inputs of WIDTH bits;
//        z/z_valid/z_ready registered output with sel = source of the beat in z.
// Option: define MUX2_ARB_LOCK_EN to add d0_last/d1_last and packet grant lock.
module mux2_arb
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d0_valid,
    input  logic [WIDTH-1:0] d0,
    output logic             d0_ready,
    input  logic             d1_valid,
    input  logic [WIDTH-1:0] d1,
    output logic             d1_ready,
`ifdef MUX2_ARB_LOCK_EN
    input  logic             d0_last,
    input  logic             d1_last,
`endif
    output logic             z_valid,
    output logic [WIDTH-1:0] z,
    input  logic             z_ready,
    output logic             sel
);

    state_t     state;
    state_t     state_nxt;
    logic       ptr;        // requester favoured on the next contention
    logic [1:0] req;
    logic [1:0] grant;
    logic       can_load;
    logic       xfer;
    logic       gsel;

`ifdef MUX2_ARB_LOCK_EN
    logic       locked;     // mid-packet: only lock_src may be granted
    logic       lock_src;
    logic       gnt_last;

    assign req      = locked ? (lock_src ? {d1_valid, 1'b0} : {1'b0, d0_valid})
                             : {d1_valid, d0_valid};
    assign gnt_last = gsel ? d1_last : d0_last;
`else
    assign req      = {d1_valid, d0_valid};
`endif

    rr_grant2 u_rr_grant2 (
        .req   (req),
        .ptr   (ptr),
        .grant (grant)
    );

    assign can_load = (state == EMPTY) || z_ready;
    assign xfer     = can_load && (grant != 2'b00);
    assign gsel     = grant[1] ? SEL_D1 : SEL_D0;

    // Readies are forced low while reset is asserted, even though the
    // output stage is EMPTY and would otherwise accept.
    assign d0_ready = rst_n && can_load && grant[0];
    assign d1_ready = rst_n && can_load && grant[1];
    assign z_valid  = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (xfer) state_nxt = FULL;
            FULL:  if (z_ready && !xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // A transfer in FULL with z_ready=1 simply overwrites the register,
    // which gives back-to-back beats with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z   <= '0;
            sel <= SEL_D0;
            ptr <= SEL_D0;
        end else if (xfer) begin
            z   <= (gsel == SEL_D1) ? d1 : d0;
            sel <= gsel;
            ptr <= ~gsel;
        end
    end

`ifdef MUX2_ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked   <= 1'b0;
            lock_src <= SEL_D0;
        end else if (xfer) begin
            locked   <= !gnt_last;
            lock_src <= gsel;
        end
    end
`endif

endmodule

// File: tb/tb_mux2_arb.sv
module tb_mux2_arb;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         d0_valid = 1'b0, d1_valid = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0;
    logic         d0_ready, d1_ready;
    logic         d0_last = 1'b1, d1_last = 1'b1;
    logic         z_valid;
    logic [W-1:0] z;
    logic         z_ready = 1'b0;
    logic         sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept at transaction level.
    bit           m_zv;
    logic [W-1:0] m_z;
    bit           m_sel;
    bit           m_lastg;   // source granted most recently
    bit           m_lk;
    bit           m_lksrc;
    int           e_g;       // expected grant this cycle, -1 = none
    bit           e_r0, e_r1;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    mux2_arb #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d0_valid (d0_valid),
        .d0       (d0),
        .d0_ready (d0_ready),
        .d1_valid (d1_valid),
        .d1       (d1),
        .d1_ready (d1_ready),
`ifdef MUX2_ARB_LOCK_EN
        .d0_last  (d0_last),
        .d1_last  (d1_last),
`endif
        .z_valid  (z_valid),
        .z        (z),
        .z_ready  (z_ready),
        .sel      (sel)
    );

    function automatic void model_reset();
        m_zv = 0; m_z = '0; m_sel = 0; m_lastg = 1; m_lk = 0; m_lksrc = 0;
        sb.delete();
    endfunction

    // Expected grant from the arbitration rules for the current inputs.
    function automatic void model_eval();
        bit can, v0, v1;
        can = !m_zv || z_ready;
        v0 = d0_valid;
        v1 = d1_valid;
        if (m_lk) begin
            if (m_lksrc) v0 = 0; else v1 = 0;
        end
        e_g = -1;
        if (v0 && v1)  e_g = m_lastg ? 0 : 1;
        else if (v0)   e_g = 0;
        else if (v1)   e_g = 1;
        if (!can || !rst_n) e_g = -1;
        e_r0 = (e_g == 0);
        e_r1 = (e_g == 1);
    endfunction

    function automatic void model_commit();
        if (!rst_n) begin
            model_reset();
        end else if (e_g >= 0) begin
            m_zv    = 1;
            m_z     = (e_g == 1) ? d1 : d0;
            m_sel   = (e_g == 1);
            m_lastg = (e_g == 1);
`ifdef MUX2_ARB_LOCK_EN
            m_lk    = !((e_g == 1) ? d1_last : d0_last);
            m_lksrc = (e_g == 1);
`endif
        end else if (z_ready) begin
            m_zv = 0;
        end
    endfunction

    task automatic apply_reset();
        rst_n = 0; d0_valid = 0; d1_valid = 0; z_ready = 0;
        d0_last = 1; d1_last = 1;
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 0; d0_valid = 1; d1_valid = 1; d0 = 8'h5A; d1 = 8'hA5; z_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (z_valid !== 1'b0) begin n_fail++; $display("FAIL reset_zv: got %b want 0", z_valid); end
        n_checks++; if (z !== 8'h00) begin n_fail++; $display("FAIL reset_z: got %h want 00", z); end
        n_checks++; if (sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0", sel); end
        n_checks++; if ({d0_ready, d1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_rdy: got %b%b want 00", d0_ready, d1_ready); end
        rst_n = 1;
        #1;
        n_checks++; if ({d0_ready, d1_ready} !== 2'b10) begin n_fail++; $display("FAIL release_rdy: got %b%b want 10", d0_ready, d1_ready); end
        model_eval(); model_commit();
        @(posedge clk); #1;
        n_checks++; if (z_valid !== 1'b1 || z !== 8'h5A || sel !== 1'b0) begin
            n_fail++; $display("FAIL release_first: got zv=%b z=%h sel=%b want zv=1 z=5a sel=0", z_valid, z, sel);
        end
    endtask

    task automatic test_single_source();
        apply_reset();
        d1_valid = 1; d1 = 8'h01; d0_valid = 0; z_ready = 1;
        for (int i = 0; i < 6; i++) begin
            d0 = W'($urandom);
            @(negedge clk); model_eval();
            n_checks++;
            if (d0_ready !== e_r0 || d1_ready !== e_r1 || z_valid !== m_zv || (m_zv && (z !== m_z || sel !== m_sel))) begin
                n_fail++; $display("FAIL single[%0d]: got rdy=%b%b zv=%b z=%h sel=%b want rdy=%b%b zv=%b z=%h sel=%b", i, d0_ready, d1_ready, z_valid, z, sel, e_r0, e_r1, m_zv, m_z, m_sel);
            end
            if (i >= 1) begin
                n_checks++;
                if (z_valid !== 1'b1 || z !== 8'h01 || sel !== 1'b1 || d1_ready !== 1'b1) begin
                    n_fail++; $display("FAIL single_const[%0d]: got zv=%b z=%h sel=%b rdy1=%b want 1 01 1 1", i, z_valid, z, sel, d1_ready);
                end
            end
            model_commit(); @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        apply_reset();
        d0_valid = 1; d1_valid = 1; d0 = 8'h00; d1 = 8'h01; z_ready = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); model_eval();
            n_checks++;
            if (d0_ready !== e_r0 || d1_ready !== e_r1 || z_valid !== m_zv || (m_zv && (z !== m_z || sel !== m_sel))) begin
                n_fail++; $display("FAIL contend[%0d]: got rdy=%b%b zv=%b z=%h sel=%b want rdy=%b%b zv=%b z=%h sel=%b", i, d0_ready, d1_ready, z_valid, z, sel, e_r0, e_r1, m_zv, m_z, m_sel);
            end
            if (i >= 1) begin
                n_checks++;
                if (sel !== 1'((i - 1) % 2) || z !== W'((i - 1) % 2)) begin
                    n_fail++; $display("FAIL contend_seq[%0d]: got sel=%b z=%h want %0d", i, sel, z, (i - 1) % 2);
                end
            end
            model_commit(); @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                d1_valid = 1; d1 = 8'h01; d0_valid = 0; z_ready = 1;
            end else if (i <= 5) begin
                z_ready = 0; d0_valid = 1'($urandom); d1_valid = 1'($urandom);
                d0 = W'($urandom); d1 = W'($urandom);
            end else if (i == 6) begin
                z_ready = 1; d0_valid = 1; d0 = 8'h33; d1_valid = 0;
            end else begin
                z_ready = 1; d0_valid = 0; d1_valid = 0;
            end
            @(negedge clk); model_eval();
            n_checks++;
            if (d0_ready !== e_r0 || d1_ready !== e_r1 || z_valid !== m_zv || (m_zv && (z !== m_z || sel !== m_sel))) begin
                n_fail++; $display("FAIL bp[%0d]: got rdy=%b%b zv=%b z=%h sel=%b want rdy=%b%b zv=%b z=%h sel=%b", i, d0_ready, d1_ready, z_valid, z, sel, e_r0, e_r1, m_zv, m_z, m_sel);
            end
            if (i >= 1 && i <= 5) begin
                n_checks++;
                if (z_valid !== 1'b1 || z !== 8'h01 || sel !== 1'b1 || {d0_ready, d1_ready} !== 2'b00) begin
                    n_fail++; $display("FAIL bp_hold[%0d]: got zv=%b z=%h sel=%b rdy=%b%b want 1 01 1 00", i, z_valid, z, sel, d0_ready, d1_ready);
                end
            end else if (i == 7) begin
                n_checks++;
                if (z_valid !== 1'b1 || z !== 8'h33 || sel !== 1'b0) begin
                    n_fail++; $display("FAIL bp_next: got zv=%b z=%h sel=%b want 1 33 0", z_valid, z, sel);
                end
            end else if (i == 8) begin
                n_checks++;
                if (z_valid !== 1'b0) begin n_fail++; $display("FAIL drain: got zv=%b want 0", z_valid); end
            end
            model_commit(); @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        d0_valid = 1; d0 = 8'h77; z_ready = 0;
        @(posedge clk); #1;
        d0_valid = 1; d1_valid = 1;
        n_checks++; if (z_valid !== 1'b1 || z !== 8'h77) begin n_fail++; $display("FAIL midrst_pre: got zv=%b z=%h want 1 77", z_valid, z); end
        rst_n = 0;
        #1;
        n_checks++; if (z_valid !== 1'b0 || {d0_ready, d1_ready} !== 2'b00) begin
            n_fail++; $display("FAIL midrst_async: got zv=%b rdy=%b%b want 0 00", z_valid, d0_ready, d1_ready);
        end
        @(negedge clk);
        d0_valid = 0; d1_valid = 0; rst_n = 1; model_reset();
        @(posedge clk); #1;
        n_checks++; if (z_valid !== 1'b0 || z !== 8'h00) begin n_fail++; $display("FAIL midrst_post: got zv=%b z=%h want 0 00", z_valid, z); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_d;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            d0_valid = ($urandom_range(0, 3) != 0); d1_valid = ($urandom_range(0, 3) != 0);
            d0 = W'($urandom); d1 = W'($urandom);
            d0_last = 1'($urandom); d1_last = 1'($urandom);
            z_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk); model_eval();
            n_checks++;
            if (d0_ready !== e_r0 || d1_ready !== e_r1 || z_valid !== m_zv || (m_zv && (z !== m_z || sel !== m_sel))) begin
                n_fail++; $display("FAIL rand[%0d]: got rdy=%b%b zv=%b z=%h sel=%b want rdy=%b%b zv=%b z=%h sel=%b", i, d0_ready, d1_ready, z_valid, z, sel, e_r0, e_r1, m_zv, m_z, m_sel);
            end
            if (z_valid && z_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rand_sb[%0d]: got z=%h want no beat", i, z);
                end else begin
                    exp_d = sb.pop_front();
                    if (z !== exp_d) begin n_fail++; $display("FAIL rand_sb[%0d]: got z=%h want %h", i, z, exp_d); end
                end
            end
            if (d0_valid && d0_ready) sb.push_back(d0);
            if (d1_valid && d1_ready) sb.push_back(d1);
            model_commit(); @(posedge clk); #1;
        end
    endtask

`ifdef MUX2_ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        z_ready = 1; d1_valid = 1; d1 = 8'hB1; d1_last = 1;
        for (int i = 0; i < 5; i++) begin
            d0_valid = (i < 3); d0 = W'(8'h10 + i); d0_last = (i == 2);
            @(negedge clk); model_eval();
            n_checks++;
            if (d0_ready !== e_r0 || d1_ready !== e_r1 || z_valid !== m_zv || (m_zv && (z !== m_z || sel !== m_sel))) begin
                n_fail++; $display("FAIL lock[%0d]: got rdy=%b%b zv=%b z=%h sel=%b want rdy=%b%b zv=%b z=%h sel=%b", i, d0_ready, d1_ready, z_valid, z, sel, e_r0, e_r1, m_zv, m_z, m_sel);
            end
            if (i >= 1) begin
                n_checks++;
                if (sel !== (i == 4)) begin n_fail++; $display("FAIL lock_sel[%0d]: got %b want %b", i, sel, (i == 4)); end
            end
            model_commit(); @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_source();
        test_contention();
        test_backpressure();
        test_mid_reset();
        test_random();
`ifdef MUX2_ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_arb.md
MUX2_ARB -- requirements
Module: mux2_arb

Interface
REQ-001 Parameter: WIDTH, 1, data width of each input and of the output.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: d0_valid  input  1  input 0 carries a beat.
REQ-005 Port: d0  input  WIDTH  input 0 data.
REQ-006 Port: d0_ready  output  1  input 0 beat is accepted this cycle.
REQ-007 Port: d1_valid, d1, d1_ready  as REQ-004..006, for input 1.
REQ-008 Port: z_valid  output  1  output register holds a beat.
REQ-009 Port: z  output  WIDTH  output data, driven from a register.
REQ-010 Port: z_ready  input  1  downstream accepts the beat.
REQ-011 Port: sel  output  1  source of the beat in z (0 = d0, 1 = d1), registered alongside z.

Function
REQ-012 The block SHALL be a two-state machine: EMPTY (z_valid=0) and FULL (z_valid=1).
REQ-013 can_load SHALL be (state==EMPTY) or (z_ready==1).
REQ-014 When can_load is 1 and exactly one input is valid, that input SHALL be granted.
REQ-015 When can_load is 1 and both inputs are valid, the input not granted last SHALL be granted (round-robin).
REQ-016 dN_ready SHALL be can_load AND grant==N; it is never 1 for both inputs in the same cycle.
REQ-017 On a granted transfer, z and sel SHALL load on the next edge, giving a latency of 1 cycle, and state goes to FULL.
REQ-018 In FULL with z_ready=1 and no valid input, the state SHALL go to EMPTY.
REQ-019 In FULL with z_ready=1 and a granted input, the register SHALL be replaced in the same cycle, giving full throughput with no bubble.
REQ-020 In FULL with z_ready=0, z, sel and z_valid SHALL hold stable and both readies SHALL be 0.
REQ-021 The round-robin pointer SHALL update only on a granted transfer.
REQ-022 When dN_valid=0, dN data SHALL be ignored.
REQ-023 Ready SHALL depend combinationally on z_ready and the valid inputs only. There are no combinational paths from valid/data to z.

Reset
REQ-024 While rst_n=0: state=EMPTY, z_valid=0, z=0, sel=0, pointer favours d0, d0_ready=0, d1_ready=0.
REQ-025 Reset asserted mid-transfer SHALL discard the held beat immediately, with no output glitch after deassertion.
REQ-026 In the first edge after rst_n rises, inputs SHALL be arbitrated normally.

Configuration
REQ-027 Macro MUX2_ARB_LOCK_EN SHALL add ports d0_last and d1_last (input, 1 bit each) and enable grant lock.
REQ-028 With MUX2_ARB_LOCK_EN defined: after a granted transfer with last=0, grant SHALL stay on that input, ignoring the other, until a transfer with last=1 from it. The pointer then advances.
REQ-029 With MUX2_ARB_LOCK_EN undefined: the last ports SHALL be absent, and every beat SHALL be arbitrated independently per REQ-014..015.

Structure
REQ-030 Shared package mux2_arb_pkg SHALL hold the state enum (EMPTY, FULL) and the source-select constants SEL_D0=0 and SEL_D1=1.
REQ-031 Round-robin grant logic SHALL be one sub-module, rr_grant2 (inputs: req[1:0], ptr; output: grant), and is instantiated once.
REQ-032 The existing mux2 SHALL NOT be instantiated. The data path select is inline, using the rr_grant2 grant.

Verification
REQ-033 Reset: hold rst_n=0 with both valid=1 -> z_valid=0, z=0, sel=0, both ready=0; release -> next edge z=d0, sel=0.
REQ-034 Single source: d1_valid=1, d1=1, d0_valid=0, z_ready=1 -> after 1 cycle z_valid=1, z=1, sel=1, with one beat per cycle.
REQ-035 Contention: both valid continuously (d0=0, d1=1), z_ready=1 -> sel sequence 0,1,0,1, and z follows 0,1,0,1.
REQ-036 Backpressure: FULL with z=1, sel=1, then z_ready=0 for 5 cycles -> z, sel, z_valid stable, both ready=0; z_ready=1 -> next beat loads with no loss and no duplicate.
REQ-037 Drain: FULL, z_ready=1, no valid -> z_valid=0 next cycle; mid-FULL reset -> z_valid=0 asynchronously.
REQ-038 Lock (MUX2_ARB_LOCK_EN): d0 sends 3 beats with last=0,0,1 while d1_valid=1 -> sel=0,0,0 then 1.
